// File: rtl/c2_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package : c2_bus_pkg
// Brief   : C1/C2 bus command codes, default bus geometry, line-beat helper.
// Rev     : 1.0
// ============================================================================
package c2_bus_pkg;

    localparam int DEF_BUS_SIZE          = 16;
    localparam int DEF_MEM_ADDR_SIZE     = 19;
    localparam int DEF_CACHE_OFFSET_SIZE = 4;
    localparam int DEF_CACHE_LINE_SIZE   = 16;

    typedef enum logic [1:0] {
        C2_NOP      = 2'd0,
        C2_RESPONSE = 2'd1,
        C2_READ     = 2'd2,
        C2_WRITE    = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        C1_NOP             = 3'd0,
        C1_READ8           = 3'd1,
        C1_READ16          = 3'd2,
        C1_READ32          = 3'd3,
        C1_INVALIDATE_LINE = 3'd4,
        C1_WRITE8          = 3'd5,
        C1_WRITE16         = 3'd6,
        C1_WRITE32         = 3'd7
    } c1_cmd_e;

    function automatic int line_beats(input int line_bytes, input int bus_bits);
        return (line_bytes * 8) / bus_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_line_array.sv
`default_nettype none
// ============================================================================
// Module : mem_line_array
// Brief  : Line-wide storage, one synchronous write port, combinational read.
// Rev    : 1.0
// ============================================================================
module mem_line_array #(
    parameter int ADDR_W = 15,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LINE_W-1:0] rdata
);

    // No reset: contents persist across reset and are undefined until written.
    logic [LINE_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module : mem_responder
// Brief  : Main-memory end of the C2 line bus; fixed-latency line read/write.
// Rev    : 1.0
// ============================================================================
module mem_responder
    import c2_bus_pkg::*;
#(
    parameter int BUS_SIZE          = DEF_BUS_SIZE,
    parameter int MEM_ADDR_SIZE     = DEF_MEM_ADDR_SIZE,
    parameter int CACHE_OFFSET_SIZE = DEF_CACHE_OFFSET_SIZE,
    parameter int CACHE_LINE_SIZE   = DEF_CACHE_LINE_SIZE,
    parameter int MEM_LATENCY       = 100
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
    inout  wire  [BUS_SIZE-1:0]                       mem_data,
    inout  wire  [1:0]                                mem_command,
    output logic                                      busy
);

    localparam int LINE_W     = CACHE_LINE_SIZE * 8;
    localparam int LINE_BEATS = line_beats(CACHE_LINE_SIZE, BUS_SIZE);
    localparam int ADDR_W     = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int CNT_W      = $clog2(MEM_LATENCY + 1);
    localparam int BEAT_W     = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WAIT_RD = 3'd1;
    localparam logic [2:0] c_SEND    = 3'd2;
    localparam logic [2:0] c_RECV    = 3'd3;
    localparam logic [2:0] c_WAIT_WR = 3'd4;
    localparam logic [2:0] c_RESP_WR = 3'd5;

    if (MEM_LATENCY < LINE_BEATS) begin : g_bad_latency
        $error("mem_responder: MEM_LATENCY must be >= LINE_BEATS");
    end
    if ((LINE_W % BUS_SIZE) != 0) begin : g_bad_bus
        $error("mem_responder: BUS_SIZE must divide the line width");
    end

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BEAT_W-1:0] r_beat;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_buf;

    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_hit;
    logic              w_last_beat;
    logic              w_we;
    logic [LINE_W-1:0] w_wdata;
    logic [LINE_W-1:0] w_rline;

    // Counter holds k-1 before edge t0+k, so the hit marks edge t0+MEM_LATENCY-1.
    assign w_cnt_next  = (r_cnt == CNT_W'(MEM_LATENCY)) ? r_cnt : r_cnt + 1'b1;
    assign w_hit       = (r_cnt == CNT_W'(MEM_LATENCY - 2));
    assign w_last_beat = (r_beat == BEAT_W'(LINE_BEATS - 1));

    // The final write beat is merged so MEM_LATENCY == LINE_BEATS can commit straight from RECV.
    always_comb begin
        w_wdata = r_buf;
        if (r_state == c_RECV) begin
            w_wdata[BUS_SIZE*r_beat +: BUS_SIZE] = mem_data;
        end
    end

    assign w_we = w_hit && ((r_state == c_WAIT_WR) || ((r_state == c_RECV) && w_last_beat));

    mem_line_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_addr),
        .wdata (w_wdata),
        .raddr (r_addr),
        .rdata (w_rline)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_addr  <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (mem_command === C2_READ) begin
                        r_addr  <= mem_address;
                        r_cnt   <= '0;
                        r_state <= c_WAIT_RD;
                    end else if (mem_command === C2_WRITE) begin
                        r_addr              <= mem_address;
                        r_cnt               <= '0;
                        r_buf[BUS_SIZE-1:0] <= mem_data;
                        r_beat              <= BEAT_W'(1);
                        r_state             <= c_RECV;
                    end
                end
                c_WAIT_RD: begin
                    r_cnt <= w_cnt_next;
                    if (w_hit) begin
                        r_beat  <= '0;
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_last_beat) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                c_RECV: begin
                    r_buf[BUS_SIZE*r_beat +: BUS_SIZE] <= mem_data;
                    r_cnt                               <= w_cnt_next;
                    if (w_last_beat) begin
                        r_state <= w_hit ? c_RESP_WR : c_WAIT_WR;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                c_WAIT_WR: begin
                    r_cnt <= w_cnt_next;
                    if (w_hit) begin
                        r_state <= c_RESP_WR;
                    end
                end
                c_RESP_WR: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != c_IDLE);
    assign mem_command = ((r_state == c_SEND) || (r_state == c_RESP_WR)) ? C2_RESPONSE : 2'bzz;
    assign mem_data    = (r_state == c_SEND) ? w_rline[BUS_SIZE*r_beat +: BUS_SIZE] : {BUS_SIZE{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_responder
// Brief  : Directed + random line traffic against a line-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_mem_responder;
    import c2_bus_pkg::*;

    localparam int SEED  = 225526;
    localparam int LAT_A = 10;
    localparam int LAT_B = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [14:0] addr;
    logic [1:0]  cmd_drv;
    logic        cmd_en;
    logic [15:0] data_drv;
    logic        data_en;

    wire  [1:0]  cmd_a, cmd_b;
    wire  [15:0] data_a, data_b;
    logic        busy_a, busy_b;

    int nerr = 0;
    int nchk = 0;
    logic [127:0] model [int];

    always #5 clk = ~clk;

    assign cmd_a  = (cmd_en && !sel)  ? cmd_drv  : 2'bzz;
    assign cmd_b  = (cmd_en && sel)   ? cmd_drv  : 2'bzz;
    assign data_a = (data_en && !sel) ? data_drv : 16'hzzzz;
    assign data_b = (data_en && sel)  ? data_drv : 16'hzzzz;

    wire [1:0]  cmd_o  = sel ? cmd_b  : cmd_a;
    wire [15:0] data_o = sel ? data_b : data_a;
    wire        busy_o = sel ? busy_b : busy_a;

    mem_responder #(.MEM_LATENCY(LAT_A)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .mem_address (addr),
        .mem_data    (data_a),
        .mem_command (cmd_a),
        .busy        (busy_a)
    );

    mem_responder #(.MEM_LATENCY(LAT_B)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .mem_address (addr),
        .mem_data    (data_b),
        .mem_command (cmd_b),
        .busy        (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A released bus reads 'z on a 4-state simulator and 0 on a 2-state one.
    function automatic logic rel2(input logic [1:0] v);
        return (v === 2'bzz) || (v === 2'b00);
    endfunction

    function automatic logic rel16(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_write(input logic [14:0] a, input logic [127:0] line, input int lat);
        addr     = a;
        cmd_drv  = C2_WRITE;
        cmd_en   = 1'b1;
        data_drv = line[15:0];
        data_en  = 1'b1;
        @(posedge clk);
        #1 cmd_en = 1'b0;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            chk("wr_busy", 32'(busy_o), 32'(n <= lat));
            if (n == lat) chk("wr_resp", 32'(cmd_o), 32'(C2_RESPONSE));
            else          chk("wr_cmd_rel", 32'(rel2(cmd_o)), 32'd1);
            if (n >= 9)   chk("wr_data_rel", 32'(rel16(data_o)), 32'd1);
            if (n < 8)  data_drv = line[16*n +: 16];
            if (n == 8) data_en = 1'b0;
        end
        model[int'(a)] = line;
    endtask

    task automatic do_read(input logic [14:0] a, input int lat, input bit intrude);
        logic [127:0] exp_line;
        exp_line = model[int'(a)];
        addr    = a;
        cmd_drv = C2_READ;
        cmd_en  = 1'b1;
        @(posedge clk);
        #1 cmd_en = 1'b0;
        for (int n = 1; n <= lat + 8; n++) begin
            @(negedge clk);
            chk("rd_busy", 32'(busy_o), 32'(n < lat + 8));
            if (n >= lat && n < lat + 8) begin
                if (!(intrude && n == lat + 3)) chk("rd_resp", 32'(cmd_o), 32'(C2_RESPONSE));
                chk("rd_beat", 32'(data_o), 32'(exp_line[16*(n-lat) +: 16]));
            end else begin
                chk("rd_cmd_rel", 32'(rel2(cmd_o)), 32'd1);
                chk("rd_data_rel", 32'(rel16(data_o)), 32'd1);
            end
            if (intrude && n == lat + 2) begin
                addr    = a ^ 15'h1;
                cmd_drv = C2_READ;
                cmd_en  = 1'b1;
            end
            if (intrude && n == lat + 3) cmd_en = 1'b0;
        end
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            chk(tag, 32'(busy_o), 32'd0);
            chk(tag, 32'(rel2(cmd_o)), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line;
        logic [127:0] old_line;
        logic [14:0]  ra [4];

        void'($urandom(SEED));
        reset    = 1'b1;
        sel      = 1'b0;
        addr     = '0;
        cmd_drv  = C2_NOP;
        cmd_en   = 1'b0;
        data_drv = '0;
        data_en  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_cmd", 32'(rel2(cmd_a)), 32'd1);
        chk("rst_data", 32'(rel16(data_a)), 32'd1);
        reset = 1'b0;

        // Line 0x0010 gets a seeded pattern, then is read back beat by beat.
        do_write(15'h0010, rand_line(), LAT_A);
        do_read(15'h0010, LAT_A, 1'b0);

        // Ordered beats 1..8, read straight after the write response.
        line = '0;
        for (int k = 0; k < 8; k++) line[16*k +: 16] = 16'(k + 1);
        do_write(15'h1234, line, LAT_A);
        do_read(15'h1234, LAT_A, 1'b0);

        // A READ landing during SEND is dropped.
        do_read(15'h1234, LAT_A, 1'b1);
        idle_check("intrude_idle", LAT_A + 10);

        // Random lines, read back in reverse order.
        for (int i = 0; i < 4; i++) begin
            ra[i] = 15'($urandom_range(16'h7fff, 16'h2000));
            do_write(ra[i], rand_line(), LAT_A);
        end
        for (int i = 3; i >= 0; i--) do_read(ra[i], LAT_A, 1'b0);

        // Reset mid-write discards the partially received line.
        old_line = rand_line();
        do_write(15'h0ABC, old_line, LAT_A);
        line     = ~old_line;
        addr     = 15'h0ABC;
        cmd_drv  = C2_WRITE;
        cmd_en   = 1'b1;
        data_drv = line[15:0];
        data_en  = 1'b1;
        @(posedge clk);
        #1 cmd_en = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            data_drv = line[16*n +: 16];
            if (n == 3) reset = 1'b1;
        end
        @(posedge clk);
        #1 data_en = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_cmd", 32'(rel2(cmd_a)), 32'd1);
        chk("abort_data", 32'(rel16(data_a)), 32'd1);
        reset = 1'b0;
        idle_check("abort_idle", LAT_A + 5);
        do_read(15'h0ABC, LAT_A, 1'b0);

        // Non-command codes in IDLE are ignored.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("junk_busy", 32'(busy_a), 32'd0);
            chk("junk_data", 32'(rel16(data_a)), 32'd1);
            addr = 15'($urandom);
            case (i % 4)
                0:       begin cmd_drv = 2'bxx;       cmd_en = 1'b1; end
                1:       begin cmd_drv = C2_NOP;      cmd_en = 1'b0; end
                2:       begin cmd_drv = C2_NOP;      cmd_en = 1'b1; end
                default: begin cmd_drv = C2_RESPONSE; cmd_en = 1'b1; end
            endcase
        end
        @(negedge clk);
        chk("junk_busy_end", 32'(busy_a), 32'd0);
        cmd_en = 1'b0;
        idle_check("junk_idle", 3);

        // Long latency: READ issued on the edge right after the write response.
        sel = 1'b1;
        @(negedge clk);
        ra[0] = 15'($urandom);
        do_write(ra[0], rand_line(), LAT_B);
        do_read(ra[0], LAT_B, 1'b0);
        idle_check("b_idle", 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
